// File: rtl/serial_add_arbiter_if.sv
// Handshake bundle between the requesters/result consumer and the serial adder arbiter.
// master = requester/consumer side, slave = arbiter side.
interface serial_add_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic                  res_carry;
    logic [IDW-1:0]        res_id;

    modport master (
        output req, req_a, req_b, res_ready,
        input  gnt, busy, res_valid, res_data, res_carry, res_id
    );

    modport slave (
        input  req, req_a, req_b, res_ready,
        output gnt, busy, res_valid, res_data, res_carry, res_id
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter feeding a bit-serial adder: one winner's operands are
// added LSB first over WIDTH cycles and the sum is held until the consumer takes it.
module serial_add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   id_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [NREQ-1:0]  gnt_reg;

    // Requests rotated so that position 0 is the requester the pointer favours.
    logic [NREQ-1:0]  req_rot;
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [IDW-1:0] idx;
            assign idx         = ptr_reg + IDW'(gi);
            assign req_rot[gi] = bus.req[idx];
        end
    endgenerate

    logic             sel_found;
    logic [IDW-1:0]   sel_off;
    logic [IDW-1:0]   sel_id;
    logic [NREQ-1:0]  sel_onehot;

    always_comb begin
        sel_found = 1'b0;
        sel_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_found = 1'b1;
                sel_off   = IDW'(k);
            end
        end
        sel_id     = ptr_reg + sel_off;
        sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_id;
    end

    logic sum_bit;
    logic carry_next;
    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            id_reg     <= '0;
            count_reg  <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            gnt_reg    <= '0;
        end else begin
            gnt_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (sel_found) begin
                        a_reg      <= bus.req_a[sel_id*WIDTH +: WIDTH];
                        b_reg      <= bus.req_b[sel_id*WIDTH +: WIDTH];
                        carry_reg  <= 1'b0;
                        count_reg  <= '0;
                        result_reg <= '0;
                        id_reg     <= sel_id;
                        ptr_reg    <= sel_id + IDW'(1);
                        gnt_reg    <= sel_onehot;
                        state_reg  <= S_ADD;
                    end
                end
                S_ADD: begin
                    carry_reg  <= carry_next;
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    result_reg <= {sum_bit, result_reg[WIDTH-1:1]};
                    if (count_reg == CW'(WIDTH - 1)) begin
                        count_reg <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.busy      = (state_reg != S_IDLE);
    assign bus.res_valid = (state_reg == S_DONE);
    assign bus.res_data  = result_reg;
    assign bus.res_carry = carry_reg;
    assign bus.res_id    = id_reg;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed plus randomized bench for serial_add_arbiter; expected grants come from a
// round-robin pointer model and expected sums from plain integer addition.
module tb_serial_add_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   ptr_m;
    logic [7:0] last_data;
    logic       last_carry;
    logic [1:0] last_id;

    serial_add_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    serial_add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_data"},  32'(bus.res_data), 32'd0);
        check({tag, "_carry"}, 32'(bus.res_carry), 32'd0);
        check({tag, "_id"},    32'(bus.res_id), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[id*8 +: 8] = a;
        bus.req_b[id*8 +: 8] = b;
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_txn(input int ready_delay, input bit drop, input logic [3:0] pulse, input bit scramble);
        logic [3:0] r;
        logic [3:0] saved;
        logic [8:0] s;
        int id;
        r  = bus.req;
        id = -1;
        if (r == 4'b0) begin
            @(negedge clk);
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (id < 0 && r[(ptr_m + k) % NREQ]) id = (ptr_m + k) % NREQ;
        end
        s = {1'b0, bus.req_a[id*8 +: 8]} + {1'b0, bus.req_b[id*8 +: 8]};
        ptr_m = (id + 1) % NREQ;
        bus.res_ready = 1'b0;

        @(negedge clk);
        check("gnt", 32'(bus.gnt), 32'd1 << id);
        check("busy", 32'(bus.busy), 32'd1);
        check("valid_early", 32'(bus.res_valid), 32'd0);
        if (drop) bus.req[id] = 1'b0;
        if (scramble) begin
            bus.req_a = $urandom;
            bus.req_b = $urandom;
        end
        saved = bus.req;
        for (int c = 2; c <= WIDTH; c++) begin
            @(negedge clk);
            check("gnt_add", 32'(bus.gnt), 32'd0);
            check("valid_add", 32'(bus.res_valid), 32'd0);
            if (c == 3) bus.req = saved | pulse;
            if (c == 5) bus.req = saved;
        end
        @(negedge clk);
        check("valid", 32'(bus.res_valid), 32'd1);
        check("data", 32'(bus.res_data), 32'(s[7:0]));
        check("carry", 32'(bus.res_carry), 32'(s[8]));
        check("id", 32'(bus.res_id), 32'(id));
        last_data  = bus.res_data;
        last_carry = bus.res_carry;
        last_id    = bus.res_id;
        repeat (ready_delay) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", 32'(bus.res_data), 32'(s[7:0]));
            check("hold_id", 32'(bus.res_id), 32'(id));
            check("hold_gnt", 32'(bus.gnt), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 32'(bus.res_valid), 32'd0);
        check("busy_drop", 32'(bus.busy), 32'd0);
        check("gnt_done", 32'(bus.gnt), 32'd0);
        $display("txn id=%0d sum=%0h carry=%0b ready_delay=%0d", id, s[7:0], s[8], ready_delay);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ptr_m  = 0;
        rst    = 1'b1;
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Single request from requester 1: 0x25 + 0x3C
        set_ops(1, 8'h25, 8'h3C);
        bus.req = 4'b0010;
        do_txn(0, 1'b1, 4'b0, 1'b0);
        check("dir1_data", 32'(last_data), 32'h61);
        check("dir1_carry", 32'(last_carry), 32'd0);
        check("dir1_id", 32'(last_id), 32'd1);

        // Carry-out case: 0xFF + 0x01 from requester 0
        set_ops(0, 8'hFF, 8'h01);
        bus.req = 4'b0001;
        do_txn(0, 1'b1, 4'b0, 1'b0);
        check("dir2_data", 32'(last_data), 32'h00);
        check("dir2_carry", 32'(last_carry), 32'd1);
        check("dir2_id", 32'(last_id), 32'd0);

        // All requesters held high after reset: grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            do_txn(0, 1'b0, 4'b0, 1'b0);
            check("rr_order", 32'(last_id), 32'(k % NREQ));
        end

        // Consumer stalls 5 cycles while others are pending
        do_txn(5, 1'b0, 4'b0, 1'b0);
        bus.req = 4'b0000;
        @(negedge clk);

        // Short req[3] pulse during busy must never be served
        bus.req = 4'b0001;
        do_txn(0, 1'b1, 4'b1000, 1'b0);
        check("pulse_id", 32'(last_id), 32'd0);
        do_txn(0, 1'b0, 4'b0, 1'b0);
        do_txn(0, 1'b0, 4'b0, 1'b0);

        // Asynchronous reset in the middle of serving requester 2
        set_ops(2, 8'h5A, 8'hC3);
        set_ops(3, 8'h11, 8'h22);
        bus.req = 4'b0100;
        @(negedge clk);
        check("rst_pre_gnt", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b0000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        bus.req = 4'b1100;
        @(negedge clk);
        check_all_zero("rst_held");
        rst   = 1'b0;
        ptr_m = 0;
        do_txn(0, 1'b1, 4'b0, 1'b0);
        check("rst_next_id", 32'(last_id), 32'd2);
        do_txn(0, 1'b1, 4'b0, 1'b0);
        check("rst_then_id", 32'(last_id), 32'd3);

        // Randomized traffic: pending bits persist, operands scrambled after grant
        for (int it = 0; it < 25; it++) begin
            bus.req_a = $urandom;
            bus.req_b = $urandom;
            bus.req   = bus.req | 4'($urandom_range(0, 15));
            do_txn(int'($urandom_range(0, 3)), 1'b1, 4'($urandom_range(0, 15)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
